ps2_entry_ctrl: RTL



---
 rtl/ps2_pkg.sv | 69 ++++++
 rtl/ps2_prefix_dec.sv | 75 +++++++
 rtl/ps2_entry_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: scancodes, key classes and FSM state encodings for the PS/2 entry path.
// Shared by ps2_prefix_dec and ps2_entry_ctrl (PS2_ENTRY_SIGNED_EN adds keypad minus).
package ps2_pkg;

  localparam logic [7:0] KC_0 = 8'h45;
  localparam logic [7:0] KC_1 = 8'h16;
  localparam logic [7:0] KC_2 = 8'h1E;
  localparam logic [7:0] KC_3 = 8'h26;
  localparam logic [7:0] KC_4 = 8'h25;
  localparam logic [7:0] KC_5 = 8'h2E;
  localparam logic [7:0] KC_6 = 8'h36;
  localparam logic [7:0] KC_7 = 8'h3D;
  localparam logic [7:0] KC_8 = 8'h3E;
  localparam logic [7:0] KC_9 = 8'h46;
  localparam logic [7:0] KC_A = 8'h1C;
  localparam logic [7:0] KC_B = 8'h32;
  localparam logic [7:0] KC_C = 8'h21;
  localparam logic [7:0] KC_D = 8'h23;
  localparam logic [7:0] KC_E = 8'h24;
  localparam logic [7:0] KC_F = 8'h2B;
  localparam logic [7:0] KC_ENTER = 8'h5A;
  localparam logic [7:0] KC_BKSP  = 8'h66;
  localparam logic [7:0] KC_TAB   = 8'h0D;
  localparam logic [7:0] KC_MINUS = 8'h7B;

  typedef enum logic [4:0] {
    LK_ENTER = 5'd16,
    LK_BKSP  = 5'd17,
    LK_TAB   = 5'd18,
    LK_OTHER = 5'd31
  } lk_special_e;

  typedef logic [1:0] pstate_t;
  localparam pstate_t P_IDLE   = 2'd0;
  localparam pstate_t P_EXT    = 2'd1;
  localparam pstate_t P_BRK    = 2'd2;
  localparam pstate_t P_EXTBRK = 2'd3;

  typedef logic [1:0] mstate_t;
  localparam mstate_t ST_EDIT = 2'd0;
  localparam mstate_t ST_BUSY = 2'd1;
  localparam mstate_t ST_WAIT = 2'd2;

  function automatic logic [4:0] key_class(input logic [7:0] c);
    case (c)
      KC_0: key_class = 5'd0;
      KC_1: key_class = 5'd1;
      KC_2: key_class = 5'd2;
      KC_3: key_class = 5'd3;
      KC_4: key_class = 5'd4;
      KC_5: key_class = 5'd5;
      KC_6: key_class = 5'd6;
      KC_7: key_class = 5'd7;
      KC_8: key_class = 5'd8;
      KC_9: key_class = 5'd9;
      KC_A: key_class = 5'd10;
      KC_B: key_class = 5'd11;
      KC_C: key_class = 5'd12;
      KC_D: key_class = 5'd13;
      KC_E: key_class = 5'd14;
      KC_F: key_class = 5'd15;
      KC_ENTER: key_class = LK_ENTER;
      KC_BKSP:  key_class = LK_BKSP;
      KC_TAB:   key_class = LK_TAB;
      default:  key_class = LK_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/ps2_prefix_dec.sv
// ps2_prefix_dec: E0/F0 prefix sequencing plus typematic repeat filter.
// Strobes are combinational in the byte_valid cycle; held tracks the key down.
module ps2_prefix_dec
  import ps2_pkg::*;
#(
  parameter logic [7:0] BRK_CODE = 8'hF0,
  parameter logic [7:0] EXT_CODE = 8'hE0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_err,
  output logic       make_stb,
  output logic       brk_stb,
  output logic       ext,
  output logic [7:0] code
);

  pstate_t    ps, ps_nxt;
  logic [7:0] held;
  logic       make_raw;

  assign code = byte_in;

  always_comb begin
    ps_nxt   = ps;
    make_raw = 1'b0;
    brk_stb  = 1'b0;
    ext      = 1'b0;
    case (ps)
      P_IDLE: begin
        if (byte_in == BRK_CODE)      ps_nxt = P_BRK;
        else if (byte_in == EXT_CODE) ps_nxt = P_EXT;
        else                          make_raw = 1'b1;
      end
      P_EXT: begin
        ext = 1'b1;
        if (byte_in == BRK_CODE) ps_nxt = P_EXTBRK;
        else begin
          make_raw = 1'b1;
          ps_nxt   = P_IDLE;
        end
      end
      P_BRK: begin
        brk_stb = 1'b1;
        ps_nxt  = P_IDLE;
      end
      default: begin
        brk_stb = 1'b1;
        ext     = 1'b1;
        ps_nxt  = P_IDLE;
      end
    endcase
    if (!byte_valid || byte_err) begin
      make_raw = 1'b0;
      brk_stb  = 1'b0;
      ps_nxt   = byte_valid ? P_IDLE : ps;
    end
  end

  assign make_stb = make_raw && (byte_in != held);

  always_ff @(posedge clk) begin
    if (rst) begin
      ps   <= P_IDLE;
      held <= 8'h00;
    end else begin
      ps <= ps_nxt;
      if (make_stb)                          held <= byte_in;
      else if (brk_stb && byte_in == held)   held <= 8'h00;
    end
  end

endmodule

// File: rtl/ps2_entry_ctrl.sv
// ps2_entry_ctrl: key events -> nibble buffer -> binary value with valid/ready.
// Define PS2_ENTRY_SIGNED_EN for keypad-minus negation in decimal mode.
module ps2_entry_ctrl
  import ps2_pkg::*;
#(
  parameter int         MAX_DIGITS = 8,
  parameter logic [7:0] BRK_CODE   = 8'hF0,
  parameter logic [7:0] EXT_CODE   = 8'hE0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  input  logic                    byte_err,
  input  logic                    hex_mode,
  output logic [31:0]             value,
  output logic                    value_valid,
  input  logic                    value_ready,
  output logic [4*MAX_DIGITS-1:0] entry,
  output logic [3:0]              digit_cnt,
  output logic [4:0]              last_key,
  output logic                    drop
`ifdef PS2_ENTRY_SIGNED_EN
  , output logic                  neg
`endif
);

  localparam int W = 4 * MAX_DIGITS;

  logic        make_stb, brk_stb, ext;
  logic [7:0]  code;
  mstate_t     st;
  logic        key_vld;
  logic [4:0]  key_cls;
  logic [31:0] acc, acc_nxt, commit_val;
  logic [3:0]  idx;
  logic        rhex;
  logic [5:0]  sa;
  logic [W-1:0] sh;
`ifdef PS2_ENTRY_SIGNED_EN
  logic        key_min;
`endif

  ps2_prefix_dec #(
    .BRK_CODE (BRK_CODE),
    .EXT_CODE (EXT_CODE)
  ) u_pre (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_err   (byte_err),
    .make_stb   (make_stb),
    .brk_stb    (brk_stb),
    .ext        (ext),
    .code       (code)
  );

  // Oldest digit first: nibble[idx-1] is the most significant remaining.
  always_comb begin
    sa = {idx - 4'd1, 2'b00};
    sh = entry >> sa;
    acc_nxt = rhex ? {acc[27:0], 4'h0}
                   : (acc << 3) + (acc << 1);
    acc_nxt = acc_nxt + {28'h0, sh[3:0]};
`ifdef PS2_ENTRY_SIGNED_EN
    commit_val = (neg && !rhex) ? (~acc_nxt + 32'd1) : acc_nxt;
`else
    commit_val = acc_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value       <= 32'h0;
      value_valid <= 1'b0;
      entry       <= '0;
      digit_cnt   <= 4'd0;
      last_key    <= LK_OTHER;
      drop        <= 1'b0;
      st          <= ST_EDIT;
      key_vld     <= 1'b0;
      key_cls     <= LK_OTHER;
      acc         <= 32'h0;
      idx         <= 4'd0;
      rhex        <= 1'b0;
`ifdef PS2_ENTRY_SIGNED_EN
      key_min     <= 1'b0;
      neg         <= 1'b0;
`endif
    end else begin
      key_vld <= 1'b0;
      if (byte_valid && byte_err) drop <= 1'b1;
      if (make_stb) begin
        if (st != ST_EDIT) drop <= 1'b1;
        else begin
          last_key <= ext ? LK_OTHER : key_class(code);
          key_vld  <= !ext;
          key_cls  <= key_class(code);
`ifdef PS2_ENTRY_SIGNED_EN
          key_min  <= (code == KC_MINUS);
`endif
        end
      end
      case (st)
        ST_EDIT: if (key_vld) begin
          unique case (1'b1)
            !key_cls[4]: begin
              if ((key_cls < 5'd10 || hex_mode) &&
                  digit_cnt < 4'(MAX_DIGITS)) begin
                entry     <= (entry << 4) | W'(key_cls[3:0]);
                digit_cnt <= digit_cnt + 4'd1;
              end
            end
            key_cls == LK_BKSP: begin
              if (digit_cnt != 4'd0) begin
                entry     <= entry >> 4;
                digit_cnt <= digit_cnt - 4'd1;
              end
            end
            key_cls == LK_TAB: begin
              entry     <= '0;
              digit_cnt <= 4'd0;
              drop      <= 1'b0;
`ifdef PS2_ENTRY_SIGNED_EN
              neg       <= 1'b0;
`endif
            end
            key_cls == LK_ENTER: begin
              rhex <= hex_mode;
              acc  <= 32'h0;
              idx  <= digit_cnt;
              if (digit_cnt == 4'd0) begin
                value       <= 32'h0;
                value_valid <= 1'b1;
                st          <= ST_WAIT;
              end else begin
                st <= ST_BUSY;
              end
            end
            default: begin
`ifdef PS2_ENTRY_SIGNED_EN
              if (key_min && !hex_mode) neg <= ~neg;
`endif
            end
          endcase
        end
        ST_BUSY: begin
          if (key_vld) drop <= 1'b1;
          acc <= acc_nxt;
          idx <= idx - 4'd1;
          if (idx == 4'd1) begin
            value       <= commit_val;
            value_valid <= 1'b1;
            st          <= ST_WAIT;
          end
        end
        default: begin
          if (key_vld) drop <= 1'b1;
          if (value_ready) begin
            value_valid <= 1'b0;
            entry       <= '0;
            digit_cnt   <= 4'd0;
            st          <= ST_EDIT;
`ifdef PS2_ENTRY_SIGNED_EN
            neg         <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule
